// File: rtl/cc_cmd_issuer.sv
// cc_cmd_issuer: sequential command initiator for the cc control/strobe bus.
// Commands arrive over valid/ready, are sequenced through SETUP -> STROBE ->
// WAIT_ACK, and complete with a registered one-cycle done (err qualifies it).
// Optional feature macro: CC_CMD_ISSUER_PARITY_EN (bus_par generation and
// read-data parity checking via the extra rd_par input).
//
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready
// are both 1; cmd_ready is 1 exactly when the FSM is IDLE, and cmd_op/cmd_data
// are only sampled on that transfer edge.
module cc_cmd_issuer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       ack,
  input  logic [7:0] rd_data,
`ifdef CC_CMD_ISSUER_PARITY_EN
  input  logic       rd_par,
`endif
  output logic       bus_i,
  output logic       bus_k,
  output logic       bus_q,
  output logic       bus_m,
  output logic       bus_p,
  output logic [7:0] bus_data,
  output logic       done,
  output logic       err,
  output logic [7:0] rsp_data,
  output logic       bus_par,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    STROBE   = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_NOP   = 2'd2;
  localparam logic [1:0] OP_BCAST = 2'd3;

  // Phase counter counts down from (length-1) to 0; reloaded on each entry.
  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  // Timeout counter counts WAIT_ACK cycles already spent, starting at 0.
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic [7:0] data_q;
  logic [3:0] phase_cnt, phase_nxt;
  logic [7:0] to_cnt, to_nxt;
  logic       done_nxt, err_nxt;
  logic       latch_cmd, cap_rsp;
  logic       par_bad;
  logic       busy;

  assign dbg_state = state;

`ifdef CC_CMD_ISSUER_PARITY_EN
  // Even parity expected from the far end on read data.
  assign par_bad = (op_q == OP_READ) && (rd_par != (^rd_data));
`else
  assign par_bad = 1'b0;
`endif

  // State and datapath registers; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_WRITE;
      data_q    <= 8'h00;
      phase_cnt <= 4'h0;
      to_cnt    <= 8'h00;
      done      <= 1'b0;
      err       <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      to_cnt    <= to_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      if (latch_cmd) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
      end
      if (cap_rsp) begin
        rsp_data <= rd_data;
      end
    end
  end

  // Next-state, counter reloads and completion decode.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    to_nxt    = to_cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    latch_cmd = 1'b0;
    cap_rsp   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_NOP) begin
            done_nxt = 1'b1;
          end else begin
            latch_cmd = 1'b1;
            state_nxt = SETUP;
            phase_nxt = SETUP_LOAD;
          end
        end
      end
      SETUP: begin
        if (phase_cnt == 4'h0) begin
          state_nxt = STROBE;
          phase_nxt = STROBE_LOAD;
        end else begin
          phase_nxt = phase_cnt - 4'h1;
        end
      end
      STROBE: begin
        if (phase_cnt == 4'h0) begin
          state_nxt = WAIT_ACK;
          to_nxt    = 8'h00;
        end else begin
          phase_nxt = phase_cnt - 4'h1;
        end
      end
      WAIT_ACK: begin
        // ack is checked before the timeout so a same-cycle ack wins.
        if (ack) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          err_nxt   = par_bad;
          cap_rsp   = (op_q == OP_READ);
        end else if (to_cnt >= TO_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else if (to_cnt != 8'hFF) begin
          to_nxt = to_cnt + 8'h01;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus lines decoded from state and the latched command.
  always_comb begin
    busy      = (state != IDLE);
    cmd_ready = (state == IDLE);
    bus_m     = busy;
    bus_i     = (state == STROBE);
    bus_k     = (state == STROBE);
    bus_q     = busy && (op_q == OP_READ);
    bus_p     = busy && (op_q == OP_BCAST);
    bus_data  = (busy && (op_q != OP_READ)) ? data_q : 8'h00;
`ifdef CC_CMD_ISSUER_PARITY_EN
    bus_par   = ^bus_data;
`else
    bus_par   = 1'b0;
`endif
  end

endmodule

// File: doc/cc_cmd_issuer.md
Name: cc_cmd_issuer

Overview:
- Sequential command initiator that drives the control/strobe bus consumed by the `cc` control decoder (lines i, k, q, m, p plus a data field).
- Accepts commands over a valid/ready handshake and sequences them through setup, strobe and acknowledge phases.
- Reports completion, timeout error and read-back data to the upstream controller.
- Sits between the host command queue and the `cc` decode logic.

Parameters:
- SETUP_CYC, 1, cycles m is asserted with the address/data stable before the strobe (1..15).
- STROBE_CYC, 2, cycles i=k=1 are held during the strobe (1..15).
- TIMEOUT, 15, maximum WAIT_ACK cycles before error (1..255).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  input  2  0=write, 1=read, 2=nop, 3=broadcast write.
- cmd_data  input  8  write data.
- ack  input  1  far-end acknowledge.
- rd_data  input  8  far-end read data, valid while ack=1.
- bus_i, bus_k  output  1  strobe select lines.
- bus_q  output  1  direction: 1=read, 0=write.
- bus_m  output  1  transaction enable.
- bus_p  output  1  broadcast flag.
- bus_data  output  8  data field.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done: timeout or parity error.
- rsp_data  output  8  captured read data, held until the next read completes.
- bus_par  output  1  even parity of bus_data (see Optional Feature).

Behaviour:
- States: IDLE, SETUP, STROBE, WAIT_ACK.
- Reset values: state=IDLE; every bus_* output, done, err and rsp_data = 0. cmd_ready=1, because it is decoded from state.
- IDLE:
  - cmd_ready=1; all bus outputs 0.
  - On handshake with op≠2: latch op and data, go to SETUP.
  - On handshake with op=2 (nop): stay in IDLE, pulse done next cycle with err=0, no bus activity.
- SETUP:
  - bus_m=1, bus_i=bus_k=0.
  - bus_q = (op==1); bus_p = (op==3).
  - bus_data = latched data for writes, 0 for reads.
  - Lasts exactly SETUP_CYC cycles, then STROBE.
- STROBE:
  - Same lines as SETUP, plus bus_i=bus_k=1.
  - Lasts exactly STROBE_CYC cycles, then WAIT_ACK.
- WAIT_ACK:
  - bus_i=bus_k=0, bus_m=1, other lines held.
  - ack is sampled only in this state; ack in any other state is ignored.
  - On ack: go to IDLE, done=1 with err=0 in the following cycle. For a read, capture rd_data into rsp_data on that same edge.
  - If TIMEOUT cycles elapse with no ack: go to IDLE, done=1 with err=1; rsp_data unchanged.
  - If ack arrives in the cycle the timeout expires, ack wins.
- done is registered:
  - It is high only in the first IDLE cycle after completion, coincident with cmd_ready=1.
  - A back-to-back command may be accepted in that same cycle.
- Latency, write with SETUP_CYC=1, STROBE_CYC=2 and ack in the first WAIT_ACK cycle:
  - Accept edge at cycle 0; SETUP in cycle 1; STROBE in cycles 2-3; WAIT_ACK in cycle 4; done in cycle 5.
- Counters:
  - Phase counter is 4 bits and reloads on each state entry.
  - Timeout counter is 8 bits, cleared on WAIT_ACK entry, and does not wrap.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. No done is generated for the aborted command.
- cmd_data and cmd_op are don't-care outside the handshake cycle.

Optional Feature:
- Macro: CC_CMD_ISSUER_PARITY_EN.
- When defined:
  - bus_par = ^bus_data during SETUP, STROBE and WAIT_ACK; 0 in IDLE.
  - An extra input rd_par (1 bit) is present.
  - A read whose ack arrives with rd_par ≠ ^rd_data completes with err=1; rsp_data is still captured.
- When undefined:
  - bus_par is tied to 0 and rd_par is absent.
  - Reads never flag a parity error.

Test Plan:
- Reset then write: cmd_op=0, cmd_data=0xA5, ack in first WAIT_ACK cycle -> bus_m=1 in cycles 1-4, bus_i=bus_k=1 only in cycles 2-3, bus_q=0, bus_data=0xA5, done=1 with err=0 in cycle 5, cmd_ready=1 in cycle 5.
- Read: cmd_op=1, ack after 3 WAIT_ACK cycles with rd_data=0x3C -> bus_q=1, bus_data=0, rsp_data=0x3C, done with err=0.
- Timeout: TIMEOUT=4, never ack -> exactly 4 WAIT_ACK cycles, then done with err=1, rsp_data unchanged, bus_m=0 afterwards.
- Nop and broadcast:
  - Nop (op=2) -> done pulse in the next cycle and no bus_m activity.
  - Broadcast (op=3, data 0x0F) -> bus_p=1 throughout the transaction.
  - Back-to-back: a second command accepted in the done cycle starts SETUP immediately.
- Reset mid-STROBE: rst_n low in cycle 2 -> all outputs 0 asynchronously, no done; a new command after release behaves normally.
- Parity (macro defined): write 0x07 -> bus_par=1. Read with rd_data=0x01 and rd_par=0 -> done with err=1, rsp_data=0x01.
